// File: rtl/reorder_buffer_pkg.sv
// Shared constants and entry payload for the reorder buffer and the forward unit.
`ifndef REORDER_BUFFER_DEFINES
`define REORDER_BUFFER_DEFINES
`define BYPASS_STATE_WIDTH 2
`define BYPASS_STATE_MISS 0
`define BYPASS_STATE_HIT 1
`define BYPASS_STATE_WAIT 2
`define DATA_SIZE 32
`endif

package reorder_buffer_pkg;

    localparam int unsigned DATA_W   = `DATA_SIZE;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned BYPASS_W = `BYPASS_STATE_WIDTH;

    localparam logic [BYPASS_W-1:0] BYPASS_MISS = BYPASS_W'(`BYPASS_STATE_MISS);
    localparam logic [BYPASS_W-1:0] BYPASS_HIT  = BYPASS_W'(`BYPASS_STATE_HIT);
    localparam logic [BYPASS_W-1:0] BYPASS_WAIT = BYPASS_W'(`BYPASS_STATE_WAIT);

    typedef struct packed {
        logic              valid;
        logic              ready;
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] value;
    } rob_entry_t;

endpackage

// File: rtl/rob_lookup.sv
// Combinational youngest-match search of one source register over the buffer.
module rob_lookup
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned TAG_W   = $clog2(ENTRIES)
) (
    input  rob_entry_t          entries [ENTRIES],
    input  logic [TAG_W-1:0]    tail,
    input  logic [REG_W-1:0]    query,
    output logic [BYPASS_W-1:0] state,
    output logic [DATA_W-1:0]   value
);

    logic             found;
    logic [TAG_W-1:0] idx;

    // Valid entries always lie in [head, tail), so walking back from tail-1
    // over every slot visits them youngest first; the first match decides.
    always_comb begin
        state = BYPASS_MISS;
        value = '0;
        found = 1'b0;
        idx   = '0;
        if (query != '0) begin
            for (int unsigned i = 1; i <= ENTRIES; i++) begin
                idx = tail - TAG_W'(i);
                if (!found && entries[idx].valid && entries[idx].dst == query) begin
                    found = 1'b1;
                    if (entries[idx].ready) begin
                        state = BYPASS_HIT;
                        value = entries[idx].value;
                    end else begin
                        state = BYPASS_WAIT;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at tail, completes by tag,
// retires from head, and answers two bypass queries per cycle.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned TAG_W   = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                alloc_valid,
    input  logic [REG_W-1:0]    alloc_dst,
    output logic                alloc_ready,
    output logic [TAG_W-1:0]    alloc_tag,
    input  logic                wb_valid,
    input  logic [TAG_W-1:0]    wb_tag,
    input  logic [DATA_W-1:0]   wb_value,
    input  logic [REG_W-1:0]    rs_query,
    input  logic [REG_W-1:0]    rt_query,
    output logic [BYPASS_W-1:0] rs_state,
    output logic [BYPASS_W-1:0] rt_state,
    output logic [DATA_W-1:0]   rs_value,
    output logic [DATA_W-1:0]   rt_value,
    output logic                commit_valid,
    output logic [REG_W-1:0]    commit_dst,
    output logic [DATA_W-1:0]   commit_value,
    output logic                full,
    output logic                empty
);

    localparam int unsigned CNT_W = TAG_W + 1;

    rob_entry_t       mem [ENTRIES];
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             alloc_fire;
    logic             wb_fire;

    assign full         = (count == CNT_W'(ENTRIES));
    assign empty        = (count == '0);
    assign alloc_ready  = !full;
    assign alloc_tag    = tail;
    assign alloc_fire   = alloc_valid && !full;
    assign wb_fire      = wb_valid && mem[wb_tag].valid && !mem[wb_tag].ready;
    assign commit_valid = mem[head].valid && mem[head].ready;
    assign commit_dst   = mem[head].dst;
    assign commit_value = mem[head].value;

    // Alloc, writeback and commit never hit the same entry: alloc needs a free
    // tail slot, writeback needs a pending entry, commit needs a ready head.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                mem[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                mem[i].valid <= 1'b0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wb_fire) begin
                mem[wb_tag].ready <= 1'b1;
                mem[wb_tag].value <= wb_value;
            end
            if (commit_valid) begin
                mem[head].valid <= 1'b0;
                head            <= head + TAG_W'(1);
            end
            if (alloc_fire) begin
                mem[tail].valid <= 1'b1;
                mem[tail].ready <= 1'b0;
                mem[tail].dst   <= alloc_dst;
                mem[tail].value <= '0;
                tail            <= tail + TAG_W'(1);
            end
            case ({alloc_fire, commit_valid})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    rob_lookup #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) u_rs_lookup (
        .entries (mem),
        .tail    (tail),
        .query   (rs_query),
        .state   (rs_state),
        .value   (rs_value)
    );

    rob_lookup #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) u_rt_lookup (
        .entries (mem),
        .tail    (tail),
        .query   (rt_query),
        .state   (rt_state),
        .value   (rt_value)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized
// traffic against a queue-based model of the in-flight instructions.
module tb_reorder_buffer;

    localparam int ENTRIES = 8;
    localparam int MISS = 0;
    localparam int HIT  = 1;
    localparam int WAIT = 2;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        alloc_valid;
    logic [4:0]  alloc_dst;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        wb_valid;
    logic [2:0]  wb_tag;
    logic [31:0] wb_value;
    logic [4:0]  rs_query;
    logic [4:0]  rt_query;
    logic [1:0]  rs_state;
    logic [1:0]  rt_state;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic        commit_valid;
    logic [4:0]  commit_dst;
    logic [31:0] commit_value;
    logic        full;
    logic        empty;

    int errors = 0;
    int checks = 0;

    // Model: program-order list of in-flight instructions, oldest first.
    int m_dst[$];
    int m_rdy[$];
    int m_val[$];
    int m_tag[$];
    int m_tail = 0;

    reorder_buffer #(.ENTRIES(ENTRIES)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .alloc_valid  (alloc_valid),
        .alloc_dst    (alloc_dst),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .wb_value     (wb_value),
        .rs_query     (rs_query),
        .rt_query     (rt_query),
        .rs_state     (rs_state),
        .rt_state     (rt_state),
        .rs_value     (rs_value),
        .rt_value     (rt_value),
        .commit_valid (commit_valid),
        .commit_dst   (commit_dst),
        .commit_value (commit_value),
        .full         (full),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        m_dst.delete(); m_rdy.delete(); m_val.delete(); m_tag.delete();
        m_tail = 0;
    endtask

    function automatic void model_query(input int r, output int st, output int val);
        st = MISS; val = 0;
        if (r != 0) begin
            for (int i = m_dst.size() - 1; i >= 0; i--) begin
                if (m_dst[i] == r) begin
                    st  = m_rdy[i] ? HIT : WAIT;
                    val = m_rdy[i] ? m_val[i] : 0;
                    return;
                end
            end
        end
    endfunction

    // Advance the model with the current inputs, then cross the clock edge.
    task automatic tick();
        int was_full;
        int retire;
        if (reset || flush) begin
            model_clear();
        end else begin
            was_full = (m_dst.size() == ENTRIES);
            retire   = (m_dst.size() > 0) && m_rdy[0];
            if (wb_valid) begin
                foreach (m_tag[i]) begin
                    if (m_tag[i] == int'(wb_tag) && !m_rdy[i]) begin
                        m_rdy[i] = 1; m_val[i] = int'(wb_value);
                    end
                end
            end
            if (retire) begin
                void'(m_dst.pop_front()); void'(m_rdy.pop_front());
                void'(m_val.pop_front()); void'(m_tag.pop_front());
            end
            if (alloc_valid && !was_full) begin
                m_dst.push_back(int'(alloc_dst)); m_rdy.push_back(0);
                m_val.push_back(0); m_tag.push_back(m_tail);
                m_tail = (m_tail + 1) % ENTRIES;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; alloc_valid = 0; alloc_dst = 0; wb_valid = 0;
        wb_tag = 0; wb_value = 0; rs_query = 0; rt_query = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        rs_query = 5; rt_query = 0;
        #1;
        checks++; if (rs_state !== 2'(MISS) || rs_value !== 32'h0) begin errors++;
            $display("FAIL reset_rs state=%0d value=%0h expected state=0 value=0", rs_state, rs_value); end
        checks++; if (empty !== 1'b1 || full !== 1'b0 || alloc_ready !== 1'b1) begin errors++;
            $display("FAIL reset_flags empty=%b full=%b ready=%b expected 1 0 1", empty, full, alloc_ready); end
        checks++; if (alloc_tag !== 3'd0) begin errors++;
            $display("FAIL reset_tag got=%0d expected=0", alloc_tag); end
        checks++; if (commit_valid !== 1'b0 || commit_dst !== 5'd0 || commit_value !== 32'h0) begin errors++;
            $display("FAIL reset_commit v=%b dst=%0d val=%0h expected 0 0 0", commit_valid, commit_dst, commit_value); end
    endtask

    task automatic test_wait_hit();
        apply_reset();
        alloc_valid = 1; alloc_dst = 3;
        tick();
        alloc_valid = 0; rs_query = 3; rt_query = 3;
        #1;
        checks++; if (rs_state !== 2'(WAIT) || rt_state !== 2'(WAIT)) begin errors++;
            $display("FAIL wait_r3 rs=%0d rt=%0d expected=2", rs_state, rt_state); end
        wb_valid = 1; wb_tag = 0; wb_value = 32'h1234;
        tick();
        wb_valid = 0;
        #1;
        checks++; if (rs_state !== 2'(HIT) || rs_value !== 32'h1234) begin errors++;
            $display("FAIL hit_r3 state=%0d value=%0h expected state=1 value=1234", rs_state, rs_value); end
        checks++; if (commit_valid !== 1'b1 || commit_dst !== 5'd3 || commit_value !== 32'h1234) begin errors++;
            $display("FAIL commit_r3 v=%b dst=%0d val=%0h expected 1 3 1234", commit_valid, commit_dst, commit_value); end
        tick();
        checks++; if (empty !== 1'b1 || commit_valid !== 1'b0 || rs_state !== 2'(MISS)) begin errors++;
            $display("FAIL retire_r3 empty=%b cv=%b rs=%0d expected 1 0 0", empty, commit_valid, rs_state); end
    endtask

    task automatic test_masking();
        apply_reset();
        alloc_valid = 1; alloc_dst = 4;
        tick();
        checks++; if (alloc_tag !== 3'd1) begin errors++;
            $display("FAIL mask_tag got=%0d expected=1", alloc_tag); end
        tick();
        alloc_valid = 0;
        wb_valid = 1; wb_tag = 0; wb_value = 7;
        tick();
        wb_valid = 0; rs_query = 4;
        #1;
        checks++; if (rs_state !== 2'(WAIT) || rs_value !== 32'h0) begin errors++;
            $display("FAIL mask_wait state=%0d value=%0h expected state=2 value=0", rs_state, rs_value); end
        wb_valid = 1; wb_tag = 1; wb_value = 9;
        tick();
        wb_valid = 0;
        #1;
        checks++; if (rs_state !== 2'(HIT) || rs_value !== 32'd9) begin errors++;
            $display("FAIL mask_hit state=%0d value=%0h expected state=1 value=9", rs_state, rs_value); end
    endtask

    task automatic test_full_wrap();
        apply_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            alloc_valid = 1; alloc_dst = 5'(10 + i);
            #1;
            checks++; if (alloc_tag !== 3'(i)) begin errors++;
                $display("FAIL fill_tag%0d got=%0d expected=%0d", i, alloc_tag, i); end
            tick();
        end
        checks++; if (full !== 1'b1 || alloc_ready !== 1'b0 || alloc_tag !== 3'd0) begin errors++;
            $display("FAIL full_flags full=%b ready=%b tag=%0d expected 1 0 0", full, alloc_ready, alloc_tag); end
        alloc_dst = 31;
        tick();
        alloc_valid = 0; rs_query = 31;
        #1;
        checks++; if (rs_state !== 2'(MISS) || alloc_tag !== 3'd0 || full !== 1'b1) begin errors++;
            $display("FAIL drop_ninth rs=%0d tag=%0d full=%b expected 0 0 1", rs_state, alloc_tag, full); end
        wb_valid = 1; wb_tag = 0; wb_value = 32'hAA;
        tick();
        wb_valid = 0; alloc_valid = 1; alloc_dst = 30; rs_query = 30;
        tick();
        alloc_valid = 0;
        #1;
        checks++; if (rs_state !== 2'(MISS) || full !== 1'b0 || alloc_tag !== 3'd0) begin errors++;
            $display("FAIL drop_with_commit rs=%0d full=%b tag=%0d expected 0 0 0", rs_state, full, alloc_tag); end
        alloc_valid = 1; alloc_dst = 20; rs_query = 20;
        tick();
        alloc_valid = 0;
        #1;
        checks++; if (full !== 1'b1 || alloc_tag !== 3'd1 || rs_state !== 2'(WAIT)) begin errors++;
            $display("FAIL wrap_alloc full=%b tag=%0d rs=%0d expected 1 1 2", full, alloc_tag, rs_state); end
    endtask

    task automatic test_flush();
        apply_reset();
        for (int i = 1; i <= 3; i++) begin
            alloc_valid = 1; alloc_dst = 5'(i);
            tick();
        end
        alloc_valid = 0;
        for (int t = 2; t >= 0; t--) begin
            wb_valid = 1; wb_tag = 3'(t); wb_value = 32'(100 + t);
            tick();
        end
        wb_valid = 0; rs_query = 2;
        #1;
        checks++; if (rs_state !== 2'(HIT) || rs_value !== 32'd101 || commit_valid !== 1'b1) begin errors++;
            $display("FAIL preflush rs=%0d val=%0h cv=%b expected 1 65 1", rs_state, rs_value, commit_valid); end
        flush = 1; alloc_valid = 1; alloc_dst = 2;
        tick();
        flush = 0; alloc_valid = 0;
        #1;
        checks++; if (empty !== 1'b1 || alloc_tag !== 3'd0 || rs_state !== 2'(MISS) || commit_valid !== 1'b0) begin errors++;
            $display("FAIL postflush empty=%b tag=%0d rs=%0d cv=%b expected 1 0 0 0", empty, alloc_tag, rs_state, commit_valid); end
    endtask

    task automatic test_r0();
        apply_reset();
        alloc_valid = 1; alloc_dst = 0;
        tick();
        alloc_valid = 0; rs_query = 0; rt_query = 0;
        #1;
        checks++; if (rs_state !== 2'(MISS) || rs_value !== 32'h0 || empty !== 1'b0) begin errors++;
            $display("FAIL r0_pending rs=%0d val=%0h empty=%b expected 0 0 0", rs_state, rs_value, empty); end
        wb_valid = 1; wb_tag = 0; wb_value = 32'h55;
        tick();
        wb_valid = 0;
        #1;
        checks++; if (rt_state !== 2'(MISS) || rt_value !== 32'h0) begin errors++;
            $display("FAIL r0_ready rt=%0d val=%0h expected 0 0", rt_state, rt_value); end
        checks++; if (commit_valid !== 1'b1 || commit_dst !== 5'd0 || commit_value !== 32'h55) begin errors++;
            $display("FAIL r0_commit v=%b dst=%0d val=%0h expected 1 0 55", commit_valid, commit_dst, commit_value); end
    endtask

    task automatic test_random();
        int est, eval, n, ecv;
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            flush       = ($urandom_range(0, 49) == 0);
            alloc_valid = ($urandom_range(0, 9) < 6);
            alloc_dst   = 5'($urandom_range(0, 7));
            wb_valid    = ($urandom_range(0, 9) < 5);
            wb_value    = $urandom;
            n = m_tag.size();
            if (n > 0 && $urandom_range(0, 9) < 8) wb_tag = 3'(m_tag[$urandom_range(0, n - 1)]);
            else wb_tag = 3'($urandom_range(0, ENTRIES - 1));
            rs_query = 5'($urandom_range(0, 7));
            rt_query = 5'($urandom_range(0, 7));
            #1;
            model_query(int'(rs_query), est, eval);
            checks++; if (rs_state !== 2'(est) || rs_value !== 32'(eval)) begin errors++;
                $display("FAIL rand_rs c%0d r%0d state=%0d val=%0h expected %0d %0h", cyc, rs_query, rs_state, rs_value, est, eval); end
            model_query(int'(rt_query), est, eval);
            checks++; if (rt_state !== 2'(est) || rt_value !== 32'(eval)) begin errors++;
                $display("FAIL rand_rt c%0d r%0d state=%0d val=%0h expected %0d %0h", cyc, rt_query, rt_state, rt_value, est, eval); end
            ecv = (m_dst.size() > 0) && m_rdy[0];
            checks++; if (commit_valid !== 1'(ecv)) begin errors++;
                $display("FAIL rand_cv c%0d got=%b expected=%0d", cyc, commit_valid, ecv); end
            if (ecv) begin
                checks++; if (commit_dst !== 5'(m_dst[0]) || commit_value !== 32'(m_val[0])) begin errors++;
                    $display("FAIL rand_commit c%0d dst=%0d val=%0h expected %0d %0h", cyc, commit_dst, commit_value, m_dst[0], m_val[0]); end
            end
            n = m_dst.size();
            checks++; if (full !== 1'(n == ENTRIES) || empty !== 1'(n == 0) || alloc_ready !== 1'(n != ENTRIES)
                          || alloc_tag !== 3'(m_tail)) begin errors++;
                $display("FAIL rand_ctrl c%0d full=%b empty=%b ready=%b tag=%0d expected count=%0d tail=%0d",
                         cyc, full, empty, alloc_ready, alloc_tag, n, m_tail); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_wait_hit();
        test_masking();
        test_full_wrap();
        test_flush();
        test_r0();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
